// File: rtl/rx_pkt_status_pkg.sv
// Shared constants for the RX packet status FIFO: FSM state encoding,
// status codes and a small status helper.
package rx_pkt_status_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_FCS = 2'd1;
    localparam logic [1:0] ST_PEND     = 2'd2;

    // Status codes stored with every entry
    localparam logic [1:0] STATUS_FCS_OK  = 2'd0;
    localparam logic [1:0] STATUS_FCS_ERR = 2'd1;
    localparam logic [1:0] STATUS_HDR_ERR = 2'd2;
    localparam logic [1:0] STATUS_ABORTED = 2'd3;

    // Map an FCS check result onto its status code
    function automatic logic [1:0] fcs_status(input logic fcs_ok);
        return fcs_ok ? STATUS_FCS_OK : STATUS_FCS_ERR;
    endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// o_data whenever o_valid is high; o_data reads as zero while empty.
// A push into a full FIFO is accepted only if a pop frees a slot that cycle.
module sync_fwft_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic                  o_accept,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [DEPTH_LOG2:0]   o_level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    logic w_full;
    logic w_pop;

    assign w_full   = (r_count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign w_pop    = i_pop & (r_count != '0);
    assign o_accept = i_push & (~w_full | w_pop);
    assign o_valid  = (r_count != '0);
    assign o_data   = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_level  = r_count;

    // Storage write port
    // NOTE: the memory array has no reset; emptiness is tracked by r_count and o_data is masked while empty.
    always_ff @(posedge clock) begin
        if (o_accept) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH
    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (o_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({o_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rx_pkt_status_fifo.sv
// Collects per-packet receive status (header info plus FCS outcome) into a
// FWFT FIFO, with a header/FCS pairing FSM, timeout and saturating statistics.
module rx_pkt_status_fifo
    import rx_pkt_status_pkg::*;
#(
    parameter int DEPTH_LOG2         = 4,
    parameter int LEN_WIDTH          = 16,
    parameter int RSSI_HALF_DB_WIDTH = 11,
    parameter int CNT_WIDTH          = 16,
    parameter int WAIT_LIMIT         = 65535
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 clear_counters,
    input  logic signed [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db,
    input  logic                                 pkt_header_valid_strobe,
    input  logic                                 pkt_header_valid,
    input  logic                                 ht_unsupport,
    input  logic [7:0]                           pkt_rate,
    input  logic [LEN_WIDTH-1:0]                 pkt_len,
    input  logic                                 fcs_out_strobe,
    input  logic                                 fcs_ok,
    input  logic                                 rd_pop,
    output logic                                 out_valid,
    output logic [7:0]                           out_rate,
    output logic [LEN_WIDTH-1:0]                 out_len,
    output logic signed [RSSI_HALF_DB_WIDTH-1:0] out_rssi,
    output logic [1:0]                           out_status,
    output logic                                 out_ht_unsupport,
    output logic [31:0]                          out_timestamp,
    output logic [DEPTH_LOG2:0]                  fifo_level,
    output logic [CNT_WIDTH-1:0]                 pkt_count,
    output logic [CNT_WIDTH-1:0]                 fcs_err_count,
    output logic [CNT_WIDTH-1:0]                 drop_count,
    output logic                                 overflow_sticky
);

    localparam int ENTRY_W = 8 + LEN_WIDTH + RSSI_HALF_DB_WIDTH + 2 + 1 + 32;
    localparam int WAIT_W  = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    logic [31:0]                          r_timestamp;
    logic [1:0]                           r_state;
    logic [WAIT_W-1:0]                    r_wait;
    logic [7:0]                           r_rate;
    logic [LEN_WIDTH-1:0]                 r_len;
    logic signed [RSSI_HALF_DB_WIDTH-1:0] r_rssi;
    logic                                 r_ht;
    logic [31:0]                          r_ts;
    logic [CNT_WIDTH-1:0]                 r_pkt_count;
    logic [CNT_WIDTH-1:0]                 r_fcs_err_count;
    logic [CNT_WIDTH-1:0]                 r_drop_count;
    logic                                 r_overflow;

    logic               w_hdr;
    logic               w_hdr_good;
    logic               w_timeout;
    logic               w_push;
    logic               w_push_live;
    logic [1:0]         w_push_status;
    logic               w_latch;
    logic               w_pend_drop;
    logic [1:0]         w_next_state;
    logic               w_accept;
    logic               w_fifo_drop;
    logic [1:0]         w_drop_inc;
    logic [ENTRY_W-1:0] w_wr_data;
    logic [ENTRY_W-1:0] w_rd_data;
    logic [CNT_WIDTH:0] w_pkt_sum;
    logic [CNT_WIDTH:0] w_err_sum;
    logic [CNT_WIDTH:0] w_drop_sum;

    // A header strobe only counts as a capture request while enabled
    assign w_hdr      = pkt_header_valid_strobe & enable;
    assign w_hdr_good = pkt_header_valid & ~ht_unsupport;
    assign w_timeout  = (r_wait == WAIT_W'(WAIT_LIMIT - 1));

    // Next-state and push decisions for the header/FCS pairing FSM
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        w_push        = 1'b0;
        w_push_live   = 1'b0;
        w_push_status = STATUS_FCS_OK;
        w_latch       = 1'b0;
        w_pend_drop   = 1'b0;
        w_next_state  = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_hdr) begin
                    w_latch = 1'b1;
                    if (w_hdr_good) begin
                        w_next_state = ST_WAIT_FCS;
                    end else begin
                        // Bad header is reported immediately from the live inputs
                        w_push        = 1'b1;
                        w_push_live   = 1'b1;
                        w_push_status = STATUS_HDR_ERR;
                    end
                end
            end
            ST_WAIT_FCS: begin
                // FCS result wins for the old entry even if a new header coincides
                if (fcs_out_strobe) begin
                    w_push        = 1'b1;
                    w_push_status = fcs_status(fcs_ok);
                    w_next_state  = ST_IDLE;
                end else if (w_hdr || w_timeout) begin
                    w_push        = 1'b1;
                    w_push_status = STATUS_ABORTED;
                    w_next_state  = ST_IDLE;
                end
                if (w_hdr) begin
                    w_latch      = 1'b1;
                    w_next_state = w_hdr_good ? ST_WAIT_FCS : ST_PEND;
                end
            end
            ST_PEND: begin
                w_push        = 1'b1;
                w_push_status = STATUS_HDR_ERR;
                w_pend_drop   = w_hdr;
                w_next_state  = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_wr_data = w_push_live
        ? {pkt_rate, pkt_len, rssi_half_db, w_push_status, ht_unsupport, r_timestamp}
        : {r_rate, r_len, r_rssi, w_push_status, r_ht, r_ts};

    sync_fwft_fifo #(
        .DATA_WIDTH (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .i_push   (w_push),
        .i_data   (w_wr_data),
        .i_pop    (rd_pop),
        .o_accept (w_accept),
        .o_valid  (out_valid),
        .o_data   (w_rd_data),
        .o_level  (fifo_level)
    );

    assign {out_rate, out_len, out_rssi, out_status, out_ht_unsupport, out_timestamp} = w_rd_data;

    // Free-running timestamp, FSM state, wait counter and latched header
    always_ff @(posedge clock) begin
        if (reset) begin
            r_timestamp <= '0;
            r_state     <= ST_IDLE;
            r_wait      <= '0;
            r_rate      <= '0;
            r_len       <= '0;
            r_rssi      <= '0;
            r_ht        <= 1'b0;
            r_ts        <= '0;
        end else begin
            r_timestamp <= r_timestamp + 32'd1;
            r_state     <= w_next_state;
            r_wait      <= (r_state == ST_WAIT_FCS && w_next_state == ST_WAIT_FCS && !w_latch)
                           ? r_wait + 1'b1 : '0;
            if (w_latch) begin
                r_rate <= pkt_rate;
                r_len  <= pkt_len;
                r_rssi <= rssi_half_db;
                r_ht   <= ht_unsupport;
                r_ts   <= r_timestamp;
            end
        end
    end

    // Drops come from a full FIFO and from headers arriving in PEND
    assign w_fifo_drop = w_push & ~w_accept;
    assign w_drop_inc  = {1'b0, w_fifo_drop} + {1'b0, w_pend_drop};
    assign w_pkt_sum   = {1'b0, r_pkt_count} + (CNT_WIDTH + 1)'(w_accept);
    assign w_err_sum   = {1'b0, r_fcs_err_count}
                       + (CNT_WIDTH + 1)'(w_accept && w_push_status == STATUS_FCS_ERR);
    assign w_drop_sum  = {1'b0, r_drop_count} + (CNT_WIDTH + 1)'(w_drop_inc);

    // Saturating statistics; clear overrides any same-cycle increment
    always_ff @(posedge clock) begin
        if (reset || clear_counters) begin
            r_pkt_count     <= '0;
            r_fcs_err_count <= '0;
            r_drop_count    <= '0;
            r_overflow      <= 1'b0;
        end else begin
            r_pkt_count     <= w_pkt_sum[CNT_WIDTH]  ? '1 : w_pkt_sum[CNT_WIDTH-1:0];
            r_fcs_err_count <= w_err_sum[CNT_WIDTH]  ? '1 : w_err_sum[CNT_WIDTH-1:0];
            r_drop_count    <= w_drop_sum[CNT_WIDTH] ? '1 : w_drop_sum[CNT_WIDTH-1:0];
            if (w_drop_inc != 2'd0) r_overflow <= 1'b1;
        end
    end

    assign pkt_count       = r_pkt_count;
    assign fcs_err_count   = r_fcs_err_count;
    assign drop_count      = r_drop_count;
    assign overflow_sticky = r_overflow;

endmodule

// File: tb/tb_rx_pkt_status_fifo.sv
// Directed bench for rx_pkt_status_fifo. A second instance with a short
// wait limit and 2-bit counters shares the stimulus for the timeout and
// counter-saturation scenarios.
module tb_rx_pkt_status_fifo;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               enable = 1'b1;
    logic               clear_counters = 1'b0;
    logic signed [10:0] rssi_half_db = '0;
    logic               pkt_header_valid_strobe = 1'b0;
    logic               pkt_header_valid = 1'b0;
    logic               ht_unsupport = 1'b0;
    logic [7:0]         pkt_rate = '0;
    logic [15:0]        pkt_len = '0;
    logic               fcs_out_strobe = 1'b0;
    logic               fcs_ok = 1'b0;
    logic               rd_pop = 1'b0;

    logic               out_valid, out_ht_unsupport, overflow_sticky;
    logic [7:0]         out_rate;
    logic [15:0]        out_len;
    logic signed [10:0] out_rssi;
    logic [1:0]         out_status;
    logic [31:0]        out_timestamp;
    logic [4:0]         fifo_level;
    logic [15:0]        pkt_count, fcs_err_count, drop_count;

    logic               t_out_valid, t_out_ht_unsupport, t_overflow_sticky;
    logic [7:0]         t_out_rate;
    logic [15:0]        t_out_len;
    logic signed [10:0] t_out_rssi;
    logic [1:0]         t_out_status;
    logic [31:0]        t_out_timestamp;
    logic [4:0]         t_fifo_level;
    logic [1:0]         t_pkt_count, t_fcs_err_count, t_drop_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    rx_pkt_status_fifo dut (
        .clock(clock), .reset(reset), .enable(enable), .clear_counters(clear_counters),
        .rssi_half_db(rssi_half_db), .pkt_header_valid_strobe(pkt_header_valid_strobe),
        .pkt_header_valid(pkt_header_valid), .ht_unsupport(ht_unsupport),
        .pkt_rate(pkt_rate), .pkt_len(pkt_len), .fcs_out_strobe(fcs_out_strobe),
        .fcs_ok(fcs_ok), .rd_pop(rd_pop), .out_valid(out_valid), .out_rate(out_rate),
        .out_len(out_len), .out_rssi(out_rssi), .out_status(out_status),
        .out_ht_unsupport(out_ht_unsupport), .out_timestamp(out_timestamp),
        .fifo_level(fifo_level), .pkt_count(pkt_count), .fcs_err_count(fcs_err_count),
        .drop_count(drop_count), .overflow_sticky(overflow_sticky)
    );

    rx_pkt_status_fifo #(.WAIT_LIMIT(8), .CNT_WIDTH(2)) dut_t (
        .clock(clock), .reset(reset), .enable(enable), .clear_counters(clear_counters),
        .rssi_half_db(rssi_half_db), .pkt_header_valid_strobe(pkt_header_valid_strobe),
        .pkt_header_valid(pkt_header_valid), .ht_unsupport(ht_unsupport),
        .pkt_rate(pkt_rate), .pkt_len(pkt_len), .fcs_out_strobe(fcs_out_strobe),
        .fcs_ok(fcs_ok), .rd_pop(rd_pop), .out_valid(t_out_valid), .out_rate(t_out_rate),
        .out_len(t_out_len), .out_rssi(t_out_rssi), .out_status(t_out_status),
        .out_ht_unsupport(t_out_ht_unsupport), .out_timestamp(t_out_timestamp),
        .fifo_level(t_fifo_level), .pkt_count(t_pkt_count), .fcs_err_count(t_fcs_err_count),
        .drop_count(t_drop_count), .overflow_sticky(t_overflow_sticky)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // One-cycle header strobe with the given fields
    task automatic hdr_cycle(input logic v, input logic ht, input logic [7:0] rate,
                             input logic [15:0] len, input logic signed [10:0] rssi);
        pkt_header_valid_strobe = 1'b1;
        pkt_header_valid        = v;
        ht_unsupport            = ht;
        pkt_rate                = rate;
        pkt_len                 = len;
        rssi_half_db            = rssi;
        step();
        pkt_header_valid_strobe = 1'b0;
    endtask

    task automatic fcs_cycle(input logic ok);
        fcs_out_strobe = 1'b1;
        fcs_ok         = ok;
        step();
        fcs_out_strobe = 1'b0;
    endtask

    task automatic pop_cycle();
        rd_pop = 1'b1;
        step();
        rd_pop = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %0b want 0", out_valid); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset fifo_level: got %0d want 0", fifo_level); end
        checks++; if ({pkt_count, fcs_err_count, drop_count} !== 48'd0) begin errors++; $display("FAIL reset counters: got %0d/%0d/%0d want 0/0/0", pkt_count, fcs_err_count, drop_count); end
        checks++; if (overflow_sticky !== 1'b0) begin errors++; $display("FAIL reset overflow_sticky: got %0b want 0", overflow_sticky); end
        checks++; if ({out_rate, out_len, out_rssi, out_status, out_ht_unsupport, out_timestamp} !== '0) begin errors++; $display("FAIL reset out fields: len=%0d ts=%0d status=%0d want all zero", out_len, out_timestamp, out_status); end
    endtask

    task automatic test_normal();
        apply_reset();
        hdr_cycle(1'b1, 1'b0, 8'h0B, 16'd100, -11'sd40);
        repeat (199) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL normal early valid: got %0b want 0", out_valid); end
        fcs_cycle(1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL normal out_valid: got %0b want 1", out_valid); end
        checks++; if (out_status !== 2'd0) begin errors++; $display("FAIL normal status: got %0d want 0", out_status); end
        checks++; if (out_len !== 16'd100 || out_rate !== 8'h0B) begin errors++; $display("FAIL normal len/rate: got %0d/%0h want 100/b", out_len, out_rate); end
        checks++; if (out_rssi !== -11'sd40) begin errors++; $display("FAIL normal rssi: got %0d want -40", out_rssi); end
        checks++; if (out_timestamp !== 32'd0) begin errors++; $display("FAIL normal timestamp: got %0d want 0", out_timestamp); end
        checks++; if (pkt_count !== 16'd1 || fcs_err_count !== 16'd0) begin errors++; $display("FAIL normal counts: got %0d/%0d want 1/0", pkt_count, fcs_err_count); end
    endtask

    task automatic test_header_fail();
        apply_reset();
        repeat (5) step();
        hdr_cycle(1'b0, 1'b0, 8'h21, 16'd77, -11'sd7);
        checks++; if (out_valid !== 1'b1 || out_status !== 2'd2) begin errors++; $display("FAIL hdr_fail push: valid=%0b status=%0d want 1/2", out_valid, out_status); end
        checks++; if (out_len !== 16'd77 || out_rate !== 8'h21 || out_rssi !== -11'sd7) begin errors++; $display("FAIL hdr_fail fields: len=%0d rate=%0h rssi=%0d want 77/21/-7", out_len, out_rate, out_rssi); end
        checks++; if (out_timestamp !== 32'd5) begin errors++; $display("FAIL hdr_fail timestamp: got %0d want 5", out_timestamp); end
        fcs_cycle(1'b1);
        checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL hdr_fail fcs in idle: level=%0d want 1", fifo_level); end
        pop_cycle();
        hdr_cycle(1'b1, 1'b1, 8'h05, 16'd12, 11'sd3);
        checks++; if (out_status !== 2'd2 || out_ht_unsupport !== 1'b1 || fifo_level !== 5'd1) begin errors++; $display("FAIL hdr_fail ht: status=%0d ht=%0b level=%0d want 2/1/1", out_status, out_ht_unsupport, fifo_level); end
    endtask

    task automatic test_preempt();
        apply_reset();
        hdr_cycle(1'b1, 1'b0, 8'h01, 16'd10, 11'sd0);
        repeat (3) step();
        hdr_cycle(1'b1, 1'b0, 8'h02, 16'd20, 11'sd0);
        checks++; if (out_valid !== 1'b1 || out_status !== 2'd3 || out_len !== 16'd10) begin errors++; $display("FAIL preempt first: valid=%0b status=%0d len=%0d want 1/3/10", out_valid, out_status, out_len); end
        fcs_cycle(1'b0);
        checks++; if (fifo_level !== 5'd2 || fcs_err_count !== 16'd1 || pkt_count !== 16'd2) begin errors++; $display("FAIL preempt counts: level=%0d err=%0d pkt=%0d want 2/1/2", fifo_level, fcs_err_count, pkt_count); end
        pop_cycle();
        checks++; if (out_status !== 2'd1 || out_len !== 16'd20) begin errors++; $display("FAIL preempt second: status=%0d len=%0d want 1/20", out_status, out_len); end
    endtask

    task automatic test_coincide();
        apply_reset();
        hdr_cycle(1'b1, 1'b0, 8'h03, 16'd30, 11'sd0);
        fcs_out_strobe = 1'b1;
        fcs_ok         = 1'b1;
        hdr_cycle(1'b1, 1'b0, 8'h04, 16'd40, 11'sd0);
        fcs_out_strobe = 1'b0;
        checks++; if (out_status !== 2'd0 || out_len !== 16'd30 || fifo_level !== 5'd1) begin errors++; $display("FAIL coincide old: status=%0d len=%0d level=%0d want 0/30/1", out_status, out_len, fifo_level); end
        fcs_cycle(1'b0);
        pop_cycle();
        checks++; if (out_status !== 2'd1 || out_len !== 16'd40 || fcs_err_count !== 16'd1) begin errors++; $display("FAIL coincide new: status=%0d len=%0d err=%0d want 1/40/1", out_status, out_len, fcs_err_count); end
    endtask

    task automatic test_pend();
        apply_reset();
        hdr_cycle(1'b1, 1'b0, 8'h05, 16'd50, 11'sd0);
        hdr_cycle(1'b0, 1'b0, 8'h06, 16'd60, 11'sd0);
        checks++; if (fifo_level !== 5'd1 || out_status !== 2'd3) begin errors++; $display("FAIL pend abort: level=%0d status=%0d want 1/3", fifo_level, out_status); end
        hdr_cycle(1'b1, 1'b0, 8'h07, 16'd70, 11'sd0);
        checks++; if (fifo_level !== 5'd2 || drop_count !== 16'd1 || overflow_sticky !== 1'b1) begin errors++; $display("FAIL pend drop: level=%0d drop=%0d sticky=%0b want 2/1/1", fifo_level, drop_count, overflow_sticky); end
        pop_cycle();
        checks++; if (out_status !== 2'd2 || out_len !== 16'd60) begin errors++; $display("FAIL pend entry: status=%0d len=%0d want 2/60", out_status, out_len); end
        fcs_cycle(1'b1);
        checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL pend dropped header latched: level=%0d want 1", fifo_level); end
    endtask

    task automatic test_enable();
        apply_reset();
        hdr_cycle(1'b1, 1'b0, 8'h08, 16'd80, 11'sd0);
        enable = 1'b0;
        hdr_cycle(1'b1, 1'b0, 8'h09, 16'd90, 11'sd0);
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL enable gated header: level=%0d want 0", fifo_level); end
        fcs_cycle(1'b1);
        checks++; if (fifo_level !== 5'd1 || out_status !== 2'd0 || out_len !== 16'd80) begin errors++; $display("FAIL enable inflight: level=%0d status=%0d len=%0d want 1/0/80", fifo_level, out_status, out_len); end
        hdr_cycle(1'b0, 1'b0, 8'h0A, 16'd91, 11'sd0);
        checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL enable idle capture: level=%0d want 1", fifo_level); end
        enable = 1'b1;
    endtask

    task automatic test_timeout();
        apply_reset();
        hdr_cycle(1'b1, 1'b0, 8'h0C, 16'd5, 11'sd0);
        repeat (7) step();
        checks++; if (t_out_valid !== 1'b0) begin errors++; $display("FAIL timeout early: valid=%0b want 0", t_out_valid); end
        step();
        checks++; if (t_out_valid !== 1'b1 || t_out_status !== 2'd3 || t_out_len !== 16'd5) begin errors++; $display("FAIL timeout push: valid=%0b status=%0d len=%0d want 1/3/5", t_out_valid, t_out_status, t_out_len); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL timeout long-limit instance: valid=%0b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_len [16];
        apply_reset();
        for (int i = 1; i <= 17; i++) hdr_cycle(1'b0, 1'b0, 8'(i), 16'(i), 11'sd0);
        checks++; if (fifo_level !== 5'd16 || drop_count !== 16'd1 || overflow_sticky !== 1'b1) begin errors++; $display("FAIL overflow: level=%0d drop=%0d sticky=%0b want 16/1/1", fifo_level, drop_count, overflow_sticky); end
        checks++; if (pkt_count !== 16'd16) begin errors++; $display("FAIL overflow pkt_count: got %0d want 16", pkt_count); end
        checks++; if (t_pkt_count !== 2'd3 || t_drop_count !== 2'd1) begin errors++; $display("FAIL overflow saturation: pkt=%0d drop=%0d want 3/1", t_pkt_count, t_drop_count); end
        rd_pop = 1'b1;
        hdr_cycle(1'b0, 1'b0, 8'd18, 16'd18, 11'sd0);
        rd_pop = 1'b0;
        checks++; if (fifo_level !== 5'd16 || drop_count !== 16'd1 || pkt_count !== 16'd17) begin errors++; $display("FAIL full push+pop: level=%0d drop=%0d pkt=%0d want 16/1/17", fifo_level, drop_count, pkt_count); end
        for (int i = 0; i < 15; i++) exp_len[i] = 16'(i + 2);
        exp_len[15] = 16'd18;
        for (int i = 0; i < 16; i++) begin
            checks++; if (out_len !== exp_len[i]) begin errors++; $display("FAIL drain entry %0d: len=%0d want %0d", i, out_len, exp_len[i]); end
            pop_cycle();
        end
        checks++; if (out_valid !== 1'b0 || fifo_level !== 5'd0) begin errors++; $display("FAIL drained: valid=%0b level=%0d want 0/0", out_valid, fifo_level); end
        pop_cycle();
        checks++; if (fifo_level !== 5'd0 || out_len !== 16'd0) begin errors++; $display("FAIL pop on empty: level=%0d len=%0d want 0/0", fifo_level, out_len); end
    endtask

    task automatic test_reset_and_clear();
        apply_reset();
        hdr_cycle(1'b1, 1'b0, 8'h0D, 16'd33, 11'sd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || fifo_level !== 5'd0) begin errors++; $display("FAIL midpkt reset: valid=%0b level=%0d want 0/0", out_valid, fifo_level); end
        fcs_cycle(1'b1);
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL midpkt reset not idle: level=%0d want 0", fifo_level); end
        hdr_cycle(1'b0, 1'b0, 8'h0E, 16'd1, 11'sd0);
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL clear pre: pkt=%0d want 1", pkt_count); end
        clear_counters = 1'b1;
        hdr_cycle(1'b0, 1'b0, 8'h0E, 16'd2, 11'sd0);
        clear_counters = 1'b0;
        checks++; if (pkt_count !== 16'd0 || fifo_level !== 5'd2) begin errors++; $display("FAIL clear priority: pkt=%0d level=%0d want 0/2", pkt_count, fifo_level); end
        hdr_cycle(1'b0, 1'b0, 8'h0E, 16'd3, 11'sd0);
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL clear post: pkt=%0d want 1", pkt_count); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_header_fail();
        test_preempt();
        test_coincide();
        test_pend();
        test_enable();
        test_timeout();
        test_overflow();
        test_reset_and_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_pkt_status_fifo.md
RX_PKT_STATUS_FIFO -- requirements
Module: rx_pkt_status_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, SHALL set the FIFO depth to 2^DEPTH_LOG2 entries.
REQ-002 Parameter LEN_WIDTH, default 16, SHALL set the packet-length field width.
REQ-003 Parameter RSSI_HALF_DB_WIDTH, default 11, SHALL set the signed RSSI field width.
REQ-004 Parameter CNT_WIDTH, default 16, SHALL set the statistics counter width.
REQ-005 Parameter WAIT_LIMIT, default 65535, SHALL set the maximum number of cycles spent waiting for FCS.
REQ-006 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-007 Ports SHALL be, in order:
- clock, in, 1, sole clock.
- reset, in, 1, synchronous active-high reset.
- enable, in, 1, gates capture of new headers.
- clear_counters, in, 1, synchronous counter clear.
- rssi_half_db, in, RSSI_HALF_DB_WIDTH, signed RSSI in half-dB steps.
- pkt_header_valid_strobe, in, 1, header-decode event.
- pkt_header_valid, in, 1, header-decode OK.
- ht_unsupport, in, 1, unsupported HT header.
- pkt_rate, in, 8, packet rate.
- pkt_len, in, LEN_WIDTH, packet length.
- fcs_out_strobe, in, 1, FCS check event.
- fcs_ok, in, 1, FCS check passed.
- rd_pop, in, 1, consume the head entry.
- out_valid, out, 1, FIFO is non-empty.
- out_rate, out, 8, head-entry rate.
- out_len, out, LEN_WIDTH, head-entry length.
- out_rssi, out, RSSI_HALF_DB_WIDTH, head-entry RSSI.
- out_status, out, 2, head-entry status code.
- out_ht_unsupport, out, 1, head-entry HT-unsupported flag.
- out_timestamp, out, 32, head-entry timestamp.
- fifo_level, out, DEPTH_LOG2+1, number of stored entries.
- pkt_count, out, CNT_WIDTH, entries committed.
- fcs_err_count, out, CNT_WIDTH, FCS_ERR entries committed.
- drop_count, out, CNT_WIDTH, entries lost.
- overflow_sticky, out, 1, set on any drop.

Function
REQ-008 A free-running 32-bit timestamp counter SHALL increment every cycle and wrap from 0xFFFFFFFF to 0.
REQ-009 Status codes SHALL be: 0 = FCS_OK, 1 = FCS_ERR, 2 = HDR_ERR, 3 = ABORTED.
REQ-010 The FSM SHALL have three states: IDLE, WAIT_FCS and PEND.
REQ-011 In IDLE, a header strobe with enable=1 SHALL latch rate, len, rssi, ht_unsupport and timestamp in the same cycle.
- If pkt_header_valid=1 and ht_unsupport=0, the FSM SHALL go to WAIT_FCS.
- Otherwise the entry SHALL be pushed in the same cycle as HDR_ERR and the FSM SHALL remain in IDLE.
REQ-012 In WAIT_FCS, fcs_out_strobe SHALL push the latched entry with status 0 if fcs_ok=1 or status 1 if fcs_ok=0, then go to IDLE.
REQ-013 In WAIT_FCS, a header strobe SHALL push the old entry as ABORTED and latch the new header.
- A valid new header SHALL keep the FSM in WAIT_FCS with the wait counter reset to 0.
- An invalid new header SHALL move the FSM to PEND.
REQ-014 In PEND, the latched entry SHALL be pushed as HDR_ERR and the FSM SHALL go to IDLE; a header strobe arriving in PEND SHALL be dropped and SHALL increment drop_count.
REQ-015 After WAIT_LIMIT cycles in WAIT_FCS without an FCS or header strobe, the latched entry SHALL be pushed as ABORTED and the FSM SHALL go to IDLE.
REQ-016 If fcs_out_strobe and a header strobe coincide in WAIT_FCS, the FCS result SHALL apply to the old entry and the new header SHALL be latched as in REQ-013.
REQ-017 enable=0 SHALL block new captures only; an in-flight WAIT_FCS entry SHALL still complete.
REQ-018 fcs_out_strobe received in IDLE or PEND SHALL be ignored.
REQ-019 The FIFO SHALL be first-word-fall-through: a pushed entry SHALL appear on the out_* ports, with out_valid=1, one cycle after the push when the FIFO was empty.
REQ-020 A push SHALL be accepted when the FIFO is not full, or when it is full and rd_pop=1 in the same cycle.
- Otherwise the entry SHALL be discarded, drop_count SHALL increment and overflow_sticky SHALL be set.
REQ-021 rd_pop with out_valid=0 SHALL be ignored; read and write pointers SHALL wrap modulo the depth.
REQ-022 pkt_count SHALL increment on every accepted push; fcs_err_count SHALL increment on every accepted status-1 push.
REQ-023 All counters SHALL saturate at their all-ones value.
REQ-024 clear_counters SHALL zero all three counters and overflow_sticky, and SHALL take priority over a same-cycle increment.

Reset
REQ-025 Reset SHALL force IDLE and empty the FIFO.
REQ-026 Reset SHALL zero all counters, the timestamp, overflow_sticky, out_valid, fifo_level and every out_* field.
REQ-027 Reset asserted mid-packet SHALL discard the latched entry without pushing it.

Structure
REQ-028 The FSM state encoding and the status-code constants SHALL live in the shared package rx_pkt_status_pkg.
REQ-029 Storage SHALL be a single sub-module, sync_fwft_fifo, parametrised by data width and DEPTH_LOG2.

Verification
REQ-030 Scenario, normal packet: header strobe (valid=1, rate=0x0B, len=100) followed 200 cycles later by fcs_ok=1.
- Required: out_valid=1 one cycle after the FCS strobe, out_status=0, out_len=100, pkt_count=1.
REQ-031 Scenario, header failure: header strobe with valid=0.
- Required: the entry is pushed the same cycle with status 2 and the FSM stays in IDLE.
REQ-032 Scenario, preemption: a second valid header arrives during WAIT_FCS.
- Required: the first entry is pushed with status 3, and the second completes with fcs_ok=0 as status 1, giving fcs_err_count=1.
REQ-033 Scenario, timeout: WAIT_LIMIT=8 with no FCS strobe.
- Required: status 3 is pushed exactly 8 cycles after entering WAIT_FCS.
REQ-034 Scenario, overflow: 17 packets with DEPTH_LOG2=4 and no pops.
- Required: fifo_level=16, drop_count=1, overflow_sticky=1.
- Then a push coinciding with rd_pop while full is accepted with no drop.
REQ-035 Scenario, reset and clear: reset asserted in WAIT_FCS; clear_counters asserted together with an accepted push.
- Required: after reset, the FIFO is empty and IDLE.
- Required: after the clear, pkt_count=0.
